x_uart_tx_cfg: RTL and testbench

X_UART_TX_CFG -- requirements
Module: x_uart_tx_cfg

---
 rtl/x_uart_tx_cfg.sv | 173 +++++++++++++++++
 tb/tb_x_uart_tx_cfg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/x_uart_tx_cfg.sv
// rtl/x_uart_tx_cfg.sv - configurable UART transmitter with TX FIFO
module x_uart_tx_cfg #(
    parameter int p_clk_hz     = 12000000,
    parameter int p_baud       = 115200,
    parameter int p_data_bits  = 8,
    parameter int p_parity     = 0,
    parameter int p_stop_bits  = 1,
    parameter int p_fifo_depth = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [p_data_bits-1:0]            i_data,
    input  logic                              i_valid,
    output logic                              o_accept,
    output logic                              o_tx,
    output logic                              o_busy,
    output logic [$clog2(p_fifo_depth):0]     o_level
);

    localparam int DIV = p_clk_hz / p_baud;
    localparam int AW  = $clog2(p_fifo_depth);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [p_data_bits-1:0] mem_q [p_fifo_depth];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [p_data_bits-1:0] shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;

    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic [p_data_bits-1:0] head;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_accept = ~full;
    // Reset gates the push so a word offered during reset never lands in the FIFO.
    assign push     = i_valid & o_accept & i_rst_n;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign bit_end  = (baud_q == CW'(DIV - 1));
    assign o_level  = wr_ptr_q - rd_ptr_q;
    assign o_busy   = (state_q != S_IDLE) || !empty;
    assign o_tx     = tx_q;

    // FIFO storage write; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    // Frame sequencing: bit timing, data shifting, FIFO pops and next line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (^head) ^ (p_parity == 1);
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(p_data_bits - 1)) begin
                        bit_d   = '0;
                        state_d = (p_parity != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == BW'(p_stop_bits - 1)) begin
                        bit_d = '0;
                        // Chain straight into the next frame when a word is waiting.
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = (^head) ^ (p_parity == 1);
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Line level follows the state being entered so o_tx lines up with it.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_x_uart_tx_cfg.sv
// tb/tb_x_uart_tx_cfg.sv - randomized bench for x_uart_tx_cfg against a frame-level model
module tb_x_uart_tx_cfg;

    localparam int DIV   = 12;
    localparam int DEPTH = 4;
    localparam int NI    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] din  [NI];
    logic       vin  [NI];
    logic       tx   [NI];
    logic       busy [NI];
    logic       acc  [NI];
    logic [2:0] lvl  [NI];

    int nb_c  [NI] = '{8, 8, 8, 7};
    int par_c [NI] = '{0, 2, 1, 0};
    int stp_c [NI] = '{1, 1, 1, 2};

    logic [15:0] fbits [NI];
    int          flen  [NI];
    int          pos   [NI];
    bit          act   [NI];
    int          cnt   [NI];
    int          rdp   [NI];
    int          npush [NI];
    logic [8:0]  mem   [NI][8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    x_uart_tx_cfg #(.p_clk_hz(12000000), .p_baud(1000000), .p_data_bits(8), .p_parity(0),
                    .p_stop_bits(1), .p_fifo_depth(DEPTH)) u_8n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[0][7:0]), .i_valid(vin[0]),
        .o_accept(acc[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_level(lvl[0]));

    x_uart_tx_cfg #(.p_clk_hz(12000000), .p_baud(1000000), .p_data_bits(8), .p_parity(2),
                    .p_stop_bits(1), .p_fifo_depth(DEPTH)) u_8e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[1][7:0]), .i_valid(vin[1]),
        .o_accept(acc[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_level(lvl[1]));

    x_uart_tx_cfg #(.p_clk_hz(12000000), .p_baud(1000000), .p_data_bits(8), .p_parity(1),
                    .p_stop_bits(1), .p_fifo_depth(DEPTH)) u_8o1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[2][7:0]), .i_valid(vin[2]),
        .o_accept(acc[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_level(lvl[2]));

    x_uart_tx_cfg #(.p_clk_hz(12000000), .p_baud(1000000), .p_data_bits(7), .p_parity(0),
                    .p_stop_bits(2), .p_fifo_depth(DEPTH)) u_7n2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[3][6:0]), .i_valid(vin[3]),
        .o_accept(acc[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_level(lvl[3]));

    task automatic chk(input string tag, input int idx, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got %0d expected %0d", tag, idx, $time, obs, exp);
        end
    endtask

    // Line bits of one frame: start, data LSB first, optional parity, stop bits.
    function automatic logic [15:0] mk_frame(input logic [8:0] w, input int nb, input int par,
                                             input int stp, output int nbits);
        logic [15:0] b;
        logic        x;
        int          k;
        b = '0;
        x = 1'b0;
        k = 1;
        for (int j = 0; j < nb; j++) begin
            b[k] = w[j];
            x    = x ^ w[j];
            k++;
        end
        if (par != 0) begin
            b[k] = (par == 2) ? x : ~x;
            k++;
        end
        for (int s = 0; s < stp; s++) begin
            b[k] = 1'b1;
            k++;
        end
        nbits = k;
        return b;
    endfunction

    // One clock: advance the model on the edge with the driven inputs, then compare.
    task automatic tick();
        bit         do_push;
        logic [8:0] w;
        int         nbits;
        int         exp_tx;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                act[i] = 1'b0;
                cnt[i] = 0;
                rdp[i] = 0;
            end else begin
                do_push = vin[i] && (cnt[i] < DEPTH);
                w       = din[i] & 9'((1 << nb_c[i]) - 1);
                if (act[i]) begin
                    pos[i]++;
                    if (pos[i] == flen[i]) act[i] = 1'b0;
                end
                if (!act[i] && cnt[i] > 0) begin
                    fbits[i] = mk_frame(mem[i][rdp[i]], nb_c[i], par_c[i], stp_c[i], nbits);
                    flen[i]  = nbits * DIV;
                    pos[i]   = 0;
                    act[i]   = 1'b1;
                    rdp[i]   = (rdp[i] + 1) % 8;
                    cnt[i]--;
                end
                if (do_push) begin
                    mem[i][(rdp[i] + cnt[i]) % 8] = w;
                    cnt[i]++;
                    npush[i]++;
                end
            end
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_tx = act[i] ? int'(fbits[i][pos[i] / DIV]) : 1;
            chk("tx", i, int'(tx[i]), exp_tx);
            chk("level", i, int'(lvl[i]), cnt[i]);
            chk("busy", i, int'(busy[i]), (act[i] || cnt[i] > 0) ? 1 : 0);
            chk("accept", i, int'(acc[i]), (cnt[i] < DEPTH) ? 1 : 0);
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0;
            din[i] = 9'($urandom);
        end
    endtask

    initial begin
        int guard;
        bit more;
        for (int i = 0; i < NI; i++) begin
            act[i] = 1'b0; cnt[i] = 0; rdp[i] = 0; pos[i] = 0; flen[i] = 0;
            npush[i] = 0; fbits[i] = '0;
        end

        // Reset held with valid asserted: nothing may be captured.
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin vin[i] = 1'b1; din[i] = 9'h1ff; end
        repeat (3) tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();

        // Directed single frames: A5 8N1, 07 even / odd parity, 41 7N2.
        din[0] = 9'h0a5; din[1] = 9'h007; din[2] = 9'h007; din[3] = 9'h041;
        for (int i = 0; i < NI; i++) vin[i] = 1'b1;
        tick();
        idle_inputs();
        repeat (150) tick();

        // Burst of five words per instance with valid held high.
        for (int i = 0; i < NI; i++) npush[i] = 0;
        guard = 0;
        more  = 1'b1;
        while (more && guard < 2000) begin
            more = 1'b0;
            for (int i = 0; i < NI; i++) begin
                vin[i] = (npush[i] < 5);
                din[i] = 9'($urandom);
                if (npush[i] < 5) more = 1'b1;
            end
            tick();
            guard++;
        end
        chk("burst_timeout", 0, (guard < 2000) ? 1 : 0, 1);
        idle_inputs();
        repeat (700) tick();

        // Reset pulse in the middle of data bit 3.
        din[0] = 9'h0a5; din[1] = 9'h0f0; din[2] = 9'h03c; din[3] = 9'h055;
        for (int i = 0; i < NI; i++) vin[i] = 1'b1;
        tick();
        idle_inputs();
        repeat (1 + 4 * DIV + DIV / 2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (200) tick();

        // Random traffic with occasional resets.
        for (int c = 0; c < 5000; c++) begin
            rst_n = ($urandom_range(0, 1499) != 0);
            for (int i = 0; i < NI; i++) begin
                vin[i] = ($urandom_range(0, 7) == 0);
                din[i] = 9'($urandom);
            end
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (700) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
